// File: rtl/pb_multi_event_counter_pkg.sv
// Shared types and helpers for the multi-channel push-button event counter.
//   debounce_state_t : per-channel debounce FSM encoding
//   sat_inc()        : counter increment that either wraps or sticks at all-ones
package pb_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } debounce_state_t;

  // Operates on a 32-bit container; callers cast the result back to their
  // own counter width. width must be 1..32.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic        saturate,
                                          input int unsigned width);
    logic [31:0] ones;
    ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (value == ones) begin
      return saturate ? ones : 32'd0;
    end
    return (value + 32'd1) & ones;
  endfunction

endpackage

// File: rtl/pb_multi_event_counter_channel.sv
// One push-button channel: 2-FF synchroniser, debounce FSM, press / release /
// hold-tick counters and a one-shot long-press detector.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   i_pb                : raw asynchronous button
//   i_clear             : zero the three counters (wins over an increment)
//   o_pressed           : debounced level (PRESSED or WAIT_RELEASE)
//   o_long_press        : 1-cycle pulse when a press reaches LONG_PRESS ticks
//   o_press_cnt, o_hold_cnt, o_release_cnt : event counters
module pb_channel
  import pb_counter_pkg::*;
#(
  parameter int DELAY      = 5_000_000,
  parameter int CNT_W      = 8,
  parameter int HOLD_TICK  = 33_000_000,
  parameter int LONG_PRESS = 3,
  parameter int SATURATE   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_pb,
  input  logic             i_clear,
  output logic             o_pressed,
  output logic             o_long_press,
  output logic [CNT_W-1:0] o_press_cnt,
  output logic [CNT_W-1:0] o_hold_cnt,
  output logic [CNT_W-1:0] o_release_cnt
);

  localparam int DB_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int HT_W = (HOLD_TICK > 1) ? $clog2(HOLD_TICK) : 1;
  localparam int LP_W = $clog2(LONG_PRESS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DELAY - 1);
  localparam logic [HT_W-1:0] HT_LAST = HT_W'(HOLD_TICK - 1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS);
  localparam logic            SAT_EN  = (SATURATE != 0);

  logic            r_sync1;
  logic            r_pb_s;
  debounce_state_t r_state;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_press_pulse;
  logic            r_release_pulse;
  logic [HT_W-1:0] r_hold_tmr;
  logic [LP_W-1:0] r_ticks;
  logic            r_long;
  logic [CNT_W-1:0] r_press_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_release_cnt;

  logic w_pressed;
  logic w_tick;

  assign w_pressed = (r_state == PRESSED) || (r_state == WAIT_RELEASE);
  // The press-pulse cycle restarts the timer, so a stale value left over from
  // the previous press must not produce a tick there.
  assign w_tick    = w_pressed && !r_press_pulse && (r_hold_tmr == HT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1         <= 1'b0;
      r_pb_s          <= 1'b0;
      r_state         <= IDLE;
      r_db_cnt        <= '0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_hold_tmr      <= '0;
      r_ticks         <= '0;
      r_long          <= 1'b0;
      r_press_cnt     <= '0;
      r_hold_cnt      <= '0;
      r_release_cnt   <= '0;
    end else begin
      r_sync1         <= i_pb;
      r_pb_s          <= r_sync1;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long          <= 1'b0;

      case (r_state)
        IDLE: begin
          if (r_pb_s) begin
            r_state  <= WAIT_PRESS;
            r_db_cnt <= '0;
          end
        end
        WAIT_PRESS: begin
          if (!r_pb_s) begin
            r_state <= IDLE;
          end else if (r_db_cnt == DB_LAST) begin
            r_state       <= PRESSED;
            r_press_pulse <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!r_pb_s) begin
            r_state  <= WAIT_RELEASE;
            r_db_cnt <= '0;
          end
        end
        WAIT_RELEASE: begin
          if (r_pb_s) begin
            r_state <= PRESSED;
          end else if (r_db_cnt == DB_LAST) begin
            r_state         <= IDLE;
            r_release_pulse <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Hold timer and per-press tick count restart with every new press.
      if (r_press_pulse) begin
        r_hold_tmr <= '0;
        r_ticks    <= '0;
      end else if (w_pressed) begin
        r_hold_tmr <= (r_hold_tmr == HT_LAST) ? '0 : r_hold_tmr + 1'b1;
      end

      // The tick count sticks at LONG_PRESS, which makes the pulse one-shot.
      if (w_tick && (r_ticks != LP_MAX)) begin
        r_ticks <= r_ticks + 1'b1;
        if (r_ticks == LP_MAX - 1'b1) begin
          r_long <= 1'b1;
        end
      end

      if (i_clear) begin
        r_press_cnt   <= '0;
        r_hold_cnt    <= '0;
        r_release_cnt <= '0;
      end else begin
        if (r_press_pulse)
          r_press_cnt <= CNT_W'(sat_inc(32'(r_press_cnt), SAT_EN, CNT_W));
        if (r_release_pulse)
          r_release_cnt <= CNT_W'(sat_inc(32'(r_release_cnt), SAT_EN, CNT_W));
        if (w_tick)
          r_hold_cnt <= CNT_W'(sat_inc(32'(r_hold_cnt), SAT_EN, CNT_W));
      end
    end
  end

  assign o_pressed     = w_pressed;
  assign o_long_press  = r_long;
  assign o_press_cnt   = r_press_cnt;
  assign o_hold_cnt    = r_hold_cnt;
  assign o_release_cnt = r_release_cnt;

endmodule

// File: rtl/pb_multi_event_counter.sv
// N-channel push-button press / hold / release counter with a registered
// channel-select mux feeding the 7-segment driver.
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   pb_in[N_CH]       : raw asynchronous buttons
//   clear_ch[N_CH]    : per-channel synchronous counter clear
//   sel               : channel shown on the count outputs (>= N_CH shows 0)
//   press_count, hold_count, release_count : selected channel's counts
//   pressed_status    : debounced level of every channel
//   long_press_pulse  : per-channel 1-cycle long-press pulse
module pb_multi_event_counter
  import pb_counter_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DELAY      = 5_000_000,
  parameter int CNT_W      = 8,
  parameter int HOLD_TICK  = 33_000_000,
  parameter int LONG_PRESS = 3,
  parameter int SATURATE   = 0,
  parameter int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  pb_in,
  input  logic [N_CH-1:0]  clear_ch,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] press_count,
  output logic [CNT_W-1:0] hold_count,
  output logic [CNT_W-1:0] release_count,
  output logic [N_CH-1:0]  pressed_status,
  output logic [N_CH-1:0]  long_press_pulse
);

  logic [CNT_W-1:0] w_press   [N_CH];
  logic [CNT_W-1:0] w_hold    [N_CH];
  logic [CNT_W-1:0] w_release [N_CH];
  logic [CNT_W-1:0] w_sel_press;
  logic [CNT_W-1:0] w_sel_hold;
  logic [CNT_W-1:0] w_sel_release;
  logic [CNT_W-1:0] r_press_count;
  logic [CNT_W-1:0] r_hold_count;
  logic [CNT_W-1:0] r_release_count;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    pb_channel #(
      .DELAY      (DELAY),
      .CNT_W      (CNT_W),
      .HOLD_TICK  (HOLD_TICK),
      .LONG_PRESS (LONG_PRESS),
      .SATURATE   (SATURATE)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .i_pb          (pb_in[gi]),
      .i_clear       (clear_ch[gi]),
      .o_pressed     (pressed_status[gi]),
      .o_long_press  (long_press_pulse[gi]),
      .o_press_cnt   (w_press[gi]),
      .o_hold_cnt    (w_hold[gi]),
      .o_release_cnt (w_release[gi])
    );
  end

  // Compare-and-pick instead of indexing, so out-of-range selects fall
  // through to zero.
  always_comb begin
    w_sel_press   = '0;
    w_sel_hold    = '0;
    w_sel_release = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        w_sel_press   = w_press[i];
        w_sel_hold    = w_hold[i];
        w_sel_release = w_release[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_press_count   <= '0;
      r_hold_count    <= '0;
      r_release_count <= '0;
    end else begin
      r_press_count   <= w_sel_press;
      r_hold_count    <= w_sel_hold;
      r_release_count <= w_sel_release;
    end
  end

  assign press_count   = r_press_count;
  assign hold_count    = r_hold_count;
  assign release_count = r_release_count;

endmodule

// File: tb/tb_pb_multi_event_counter.sv
module tb_pb_multi_event_counter;

  localparam int N_CH = 2;
  localparam int CNT_W = 4;
  localparam int SEL_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  pb_in;
  logic [N_CH-1:0]  clear_ch;
  logic [SEL_W-1:0] sel;

  logic [CNT_W-1:0] w_press, w_hold, w_release;
  logic [N_CH-1:0]  w_ps, w_lp;
  logic [CNT_W-1:0] s_press, s_hold, s_release;
  logic [N_CH-1:0]  s_ps, s_lp;

  always #5 clock = ~clock;

  pb_multi_event_counter #(
    .N_CH(N_CH), .DELAY(4), .CNT_W(CNT_W), .HOLD_TICK(10),
    .LONG_PRESS(2), .SATURATE(0), .SEL_W(SEL_W)
  ) u_wrap (
    .clock(clock), .reset(reset), .pb_in(pb_in), .clear_ch(clear_ch), .sel(sel),
    .press_count(w_press), .hold_count(w_hold), .release_count(w_release),
    .pressed_status(w_ps), .long_press_pulse(w_lp)
  );

  pb_multi_event_counter #(
    .N_CH(N_CH), .DELAY(4), .CNT_W(CNT_W), .HOLD_TICK(10),
    .LONG_PRESS(2), .SATURATE(1), .SEL_W(SEL_W)
  ) u_sat (
    .clock(clock), .reset(reset), .pb_in(pb_in), .clear_ch(clear_ch), .sel(sel),
    .press_count(s_press), .hold_count(s_hold), .release_count(s_release),
    .pressed_status(s_ps), .long_press_pulse(s_lp)
  );

  // Observed-value selectors for scoreboard entries.
  localparam int K_PRESS = 0, K_HOLD = 1, K_REL = 2, K_PS = 3, K_LP0CNT = 4,
                 K_PS1CNT = 5, K_SPRESS = 6, K_SREL = 7, K_LP = 8;

  typedef struct {
    string name;
    int    kind;
    int    exp;
    int    at;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   lp0_cnt = 0;
  int   ps1_cnt = 0;
  logic done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int actual(input int k);
    case (k)
      K_PRESS:  return int'(w_press);
      K_HOLD:   return int'(w_hold);
      K_REL:    return int'(w_release);
      K_PS:     return int'(w_ps);
      K_LP0CNT: return lp0_cnt;
      K_PS1CNT: return ps1_cnt;
      K_SPRESS: return int'(s_press);
      K_SREL:   return int'(s_release);
      K_LP:     return int'(w_lp);
      default:  return -1;
    endcase
  endfunction

  // Monitor: samples on the falling edge and retires every due expectation.
  always @(negedge clock) begin
    chk_t c;
    int   act;
    if (w_lp[0]) lp0_cnt = lp0_cnt + 1;
    if (w_ps[1]) ps1_cnt = ps1_cnt + 1;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      c   = sb.pop_front();
      act = actual(c.kind);
      vectors = vectors + 1;
      if (act != c.exp) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
    if (done) begin
      if (sb.size() != 0) begin
        miscompares = miscompares + sb.size();
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic expect_at(input string n, input int k, input int e, input int dly = 0);
    sb.push_back('{name: n, kind: k, exp: e, at: cyc + dly});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic press_ch(input int ch, input int hold, input int gap);
    pb_in[ch] = 1'b1;
    step(hold);
    pb_in[ch] = 1'b0;
    step(gap);
  endtask

  initial begin
    reset    = 1'b1;
    pb_in    = '0;
    clear_ch = '0;
    sel      = '0;
    step(2);
    expect_at("reset_press", K_PRESS, 0);
    expect_at("reset_hold", K_HOLD, 0);
    expect_at("reset_release", K_REL, 0);
    expect_at("reset_pressed_status", K_PS, 0);
    expect_at("reset_long_pulse", K_LP, 0);
    reset = 1'b0;
    step(1);

    // Bounce on ch1: two short highs never survive the debounce window.
    sel = 2'd1;
    pb_in[1] = 1'b1; step(2);
    pb_in[1] = 1'b0; step(1);
    pb_in[1] = 1'b1; step(2);
    pb_in[1] = 1'b0; step(12);
    expect_at("bounce_press", K_PRESS, 0);
    expect_at("bounce_release", K_REL, 0);
    expect_at("bounce_hold", K_HOLD, 0);
    expect_at("bounce_pressed_cycles", K_PS1CNT, 0);

    // Clean 30-cycle press on ch0: press pulse 7 cycles after pb_in rises,
    // hold ticks 11 and 21 cycles later, release 7 cycles after the drop.
    sel = 2'd0;
    press_ch(0, 30, 20);
    expect_at("clean_press", K_PRESS, 1);
    expect_at("clean_hold", K_HOLD, 2);
    expect_at("clean_release", K_REL, 1);
    expect_at("clean_long_pulses", K_LP0CNT, 1);
    expect_at("clean_pressed_status", K_PS, 0);

    // Release glitch: two low cycles while PRESSED must not release.
    do_reset();
    sel = 2'd0;
    pb_in[0] = 1'b1; step(12);
    pb_in[0] = 1'b0; step(2);
    pb_in[0] = 1'b1; step(10);
    expect_at("glitch_release", K_REL, 0);
    expect_at("glitch_press", K_PRESS, 1);
    expect_at("glitch_pressed_status", K_PS, 1);
    pb_in[0] = 1'b0; step(12);
    expect_at("glitch_final_release", K_REL, 1);
    expect_at("glitch_final_press", K_PRESS, 1);

    // 17 presses: 4-bit wrap gives 1, saturating instance holds 15.
    do_reset();
    sel = 2'd0;
    for (int i = 0; i < 17; i++) press_ch(0, 8, 8);
    step(4);
    expect_at("wrap_press", K_PRESS, 1);
    expect_at("wrap_release", K_REL, 1);
    expect_at("sat_press", K_SPRESS, 15);
    expect_at("sat_release", K_SREL, 15);

    // Simultaneous presses on both channels.
    do_reset();
    sel = 2'd0;
    pb_in = 2'b11; step(9);
    pb_in = 2'b00; step(12);
    expect_at("simul_ch0_press", K_PRESS, 1);
    sel = 2'd1; step(2);
    expect_at("simul_ch1_press", K_PRESS, 1);
    press_ch(1, 9, 12);
    sel = 2'd0; step(2);
    expect_at("sel0_press", K_PRESS, 1);
    // Mux is registered: value changes only after the next clock edge.
    sel = 2'd1;
    expect_at("sel_latency_before", K_PRESS, 1);
    expect_at("sel_latency_after", K_PRESS, 2, 1);
    step(2);
    sel = 2'd2; step(2);
    expect_at("sel_oob_press", K_PRESS, 0);
    expect_at("sel_oob_hold", K_HOLD, 0);
    expect_at("sel_oob_release", K_REL, 0);

    // Clear coincident with the press increment (edge 8 after pb_in rises).
    do_reset();
    sel = 2'd0;
    pb_in[0] = 1'b1; step(7);
    clear_ch = 2'b01; step(1);
    clear_ch = 2'b00; step(4);
    expect_at("clear_press", K_PRESS, 0);
    expect_at("clear_keeps_fsm", K_PS, 1);
    pb_in[0] = 1'b0; step(12);
    expect_at("clear_then_release", K_REL, 1);
    expect_at("clear_then_press", K_PRESS, 0);

    // Reset while ch1 is pressed.
    do_reset();
    sel = 2'd1;
    pb_in[1] = 1'b1; step(12);
    expect_at("pre_reset_press", K_PRESS, 1);
    expect_at("pre_reset_status", K_PS, 2);
    reset = 1'b1;
    pb_in = 2'b00;
    expect_at("midreset_press", K_PRESS, 0, 1);
    expect_at("midreset_hold", K_HOLD, 0, 1);
    expect_at("midreset_release", K_REL, 0, 1);
    expect_at("midreset_status", K_PS, 0, 1);
    step(1);
    reset = 1'b0;
    step(15);
    expect_at("post_reset_release", K_REL, 0);
    expect_at("post_reset_press", K_PRESS, 0);

    step(2);
    done = 1'b1;
  end

endmodule
